// File: rtl/fuzzy_pkg.sv
// Shared types and sizing constants for the fuzzy risk core frame initiator.
package fuzzy_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 8;
  localparam int IDX_W     = 3;
  localparam int HOLD_W    = 4;
  localparam int PACE_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    SETTLE,
    RESULT,
    GAP
  } state_e;

endpackage

// File: rtl/fuzzy_pace_cnt.sv
// Loadable down-counter with a zero flag; a load takes priority over counting.
module fuzzy_pace_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fuzzy_frame_tx.sv
// Frame initiator: buffers operand bytes, strobes them to the core, samples risk.
// Optional RISK_ALARM_EN adds ALARM_THRESH and a registered alarm output.
module fuzzy_frame_tx
  import fuzzy_pkg::*;
#(
  parameter int NUM_BYTES     = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2
`ifdef RISK_ALARM_EN
  ,
  parameter logic [7:0] ALARM_THRESH = 8'd200
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ss_n,
  output logic [7:0] data_bus,
  input  logic [7:0] risk_in,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
`ifdef RISK_ALARM_EN
  ,
  output logic       alarm
`endif
);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] frame_q [MAX_BYTES];
  logic [BYTE_W-1:0] frame_d [MAX_BYTES];
  logic [BYTE_W-1:0] res_data_q, res_data_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              last_idx;
  logic              hold_load, hold_en, hold_zero;
  logic              pace_load, pace_en, pace_zero;
  logic [PACE_W-1:0] pace_val;

  assign accept   = in_valid & in_ready_q;
  assign last_idx = (idx_q == IDX_W'(NUM_BYTES - 1));

  // Hold counter paces each byte on data_bus; reloaded per byte.
  assign hold_en   = (state_q == SEND);
  assign hold_load = ((state_d == SEND) && (state_q != SEND)) ||
                     ((state_q == SEND) && hold_zero && !last_idx);

  fuzzy_pace_cnt #(
    .WIDTH(HOLD_W)
  ) u_hold_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .load_val(HOLD_W'(HOLD_CYCLES - 1)),
    .en      (hold_en),
    .zero    (hold_zero)
  );

  // SETTLE and GAP never overlap, so one counter serves both.
  assign pace_en   = (state_q == SETTLE) || (state_q == GAP);
  assign pace_load = ((state_d == SETTLE) && (state_q != SETTLE)) ||
                     ((state_d == GAP) && (state_q != GAP));
  assign pace_val  = (state_d == SETTLE) ? PACE_W'(SETTLE_CYCLES - 1)
                                         : PACE_W'(GAP_CYCLES - 1);

  fuzzy_pace_cnt #(
    .WIDTH(PACE_W)
  ) u_pace_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pace_load),
    .load_val(pace_val),
    .en      (pace_en),
    .zero    (pace_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (NUM_BYTES == 1) ? SEND : LOAD;
        end
      end
      LOAD: begin
        if (accept && last_idx) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (hold_zero && last_idx) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (pace_zero) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (pace_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered so it reads 0 while reset is held.
  always_comb begin
    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    in_ready   = in_ready_q;
    ss_n       = (state_q != SEND);
    data_bus   = (state_q == SEND) ? frame_q[idx_q] : '0;
    res_valid  = (state_q == RESULT);
    res_data   = res_data_q;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    idx_d      = idx_q;
    frame_d    = frame_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d[0] = in_data;
          idx_d      = (NUM_BYTES == 1) ? '0 : IDX_W'(1);
        end
      end
      LOAD: begin
        if (accept) begin
          frame_d[idx_q] = in_data;
          idx_d          = last_idx ? '0 : idx_q + IDX_W'(1);
        end
      end
      SEND: begin
        if (hold_zero) begin
          idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
      end
      SETTLE: begin
        if (pace_zero) begin
          res_data_d = risk_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      res_data_q <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      res_data_q <= res_data_d;
      in_ready_q <= in_ready_d;
      frame_q    <= frame_d;
    end
  end

`ifdef RISK_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if ((state_q == SETTLE) && pace_zero) begin
      alarm_d = (risk_in >= ALARM_THRESH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_fuzzy_frame_tx.sv
// Self-checking bench for fuzzy_frame_tx: two instances (HOLD 1 and HOLD 3),
// directed vector table, reset-mid-SEND sequence and randomized frames.
module tb_fuzzy_frame_tx;

  localparam int N    = 2;
  localparam int S    = 4;
  localparam int G    = 2;
  localparam int H_A  = 1;
  localparam int H_B  = 3;
  localparam int HIST = 16384;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0][7:0] in_data_w;
  logic [1:0]      in_valid_w;
  logic [1:0]      in_ready_w;
  logic [1:0]      ss_n_w;
  logic [1:0][7:0] data_bus_w;
  logic [7:0]      risk_in;
  logic [1:0][7:0] res_data_w;
  logic [1:0]      res_valid_w;
  logic [1:0]      res_ready_w;
  logic [1:0]      busy_w;
`ifdef RISK_ALARM_EN
  logic [1:0]      alarm_w;
`endif

  int         n_compared = 0;
  int         n_mismatch = 0;
  int         cyc = 0;
  int         last_rise [2];
  bit         risk_fixed = 1'b1;
  logic [7:0] risk_val = 8'h00;
  logic [7:0] risk_hist [0:HIST-1];

  typedef struct {
    int         dut;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] risk;
    int         gap;
    int         rdy;
    logic [7:0] exp_res;
    logic       exp_alarm;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  fuzzy_frame_tx #(
    .NUM_BYTES(N), .HOLD_CYCLES(H_A), .SETTLE_CYCLES(S), .GAP_CYCLES(G)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_w[0]), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .ss_n(ss_n_w[0]), .data_bus(data_bus_w[0]), .risk_in(risk_in),
    .res_data(res_data_w[0]), .res_valid(res_valid_w[0]), .res_ready(res_ready_w[0]),
    .busy(busy_w[0])
`ifdef RISK_ALARM_EN
    , .alarm(alarm_w[0])
`endif
  );

  fuzzy_frame_tx #(
    .NUM_BYTES(N), .HOLD_CYCLES(H_B), .SETTLE_CYCLES(S), .GAP_CYCLES(G)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_w[1]), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .ss_n(ss_n_w[1]), .data_bus(data_bus_w[1]), .risk_in(risk_in),
    .res_data(res_data_w[1]), .res_valid(res_valid_w[1]), .res_ready(res_ready_w[1]),
    .busy(busy_w[1])
`ifdef RISK_ALARM_EN
    , .alarm(alarm_w[1])
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic flagTimeout(input string name);
    n_compared++;
    n_mismatch++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic applyStimulus(input int d, input logic v, input logic [7:0] data,
                               input logic rdy);
    in_valid_w[d]  = v;
    in_data_w[d]   = data;
    res_ready_w[d] = rdy;
  endtask

  // Advance to the next falling edge and present a fresh risk value.
  task automatic tick();
    @(negedge clk);
    cyc++;
    risk_in = risk_fixed ? risk_val : 8'($urandom);
    if (cyc < HIST) risk_hist[cyc] = risk_in;
  endtask

  task automatic run_frame(input int d, input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input int rdy, input bit fixed,
                           input logic [7:0] fixed_val, input logic [7:0] exp_res_tab,
                           input logic exp_alarm_tab);
    int         h;
    int         waited;
    int         r;
    int         v;
    int         s_low;
    logic       rdy_hi;
    logic [7:0] exp_res;
    logic       exp_alarm;
    logic [7:0] exp_byte;
    logic [7:0] trace [$];

    h          = (d == 0) ? H_A : H_B;
    rdy_hi     = (rdy < 0);
    risk_fixed = fixed;
    risk_val   = fixed_val;
    exp_alarm  = 1'b0;
    applyStimulus(d, 1'b0, 8'($urandom), rdy_hi);

    waited = 0;
    while (!in_ready_w[d] && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready_w[d]) begin
      flagTimeout("wait_in_ready");
      return;
    end

    applyStimulus(d, 1'b1, b0, rdy_hi);
    tick();
    checkOutput("load_in_ready", in_ready_w[d], 1);
    checkOutput("load_ss_n", ss_n_w[d], 1);
    checkOutput("load_busy", busy_w[d], 1);

    for (int g = 0; g < gap; g++) begin
      applyStimulus(d, 1'b0, 8'($urandom), rdy_hi);
      tick();
      checkOutput("loadwait_ss_n", ss_n_w[d], 1);
      checkOutput("loadwait_bus", data_bus_w[d], 0);
    end

    applyStimulus(d, 1'b1, b1, rdy_hi);
    tick();
    applyStimulus(d, 1'b0, 8'($urandom), rdy_hi);
    s_low = cyc;
    if (last_rise[d] >= 0) begin
      checkOutput("ss_high_min", ((s_low - last_rise[d]) >= (S + 1 + G)), 1);
    end

    while (ss_n_w[d] == 1'b0 && trace.size() < 40) begin
      trace.push_back(data_bus_w[d]);
      checkOutput("send_in_ready", in_ready_w[d], 0);
      tick();
    end
    checkOutput("ss_low_len", trace.size(), N * h);
    for (int i = 0; i < trace.size() && i < N * h; i++) begin
      exp_byte = ((i / h) == 0) ? b0 : b1;
      checkOutput("send_byte", trace[i], exp_byte);
    end

    r = cyc;
    last_rise[d] = r;
    checkOutput("settle_bus", data_bus_w[d], 0);

    waited = 0;
    while (!res_valid_w[d] && waited < 300) begin
      tick();
      waited++;
    end
    if (!res_valid_w[d]) begin
      flagTimeout("wait_res_valid");
      return;
    end
    v = cyc;
    checkOutput("settle_len", v - r, S);

    if (fixed) begin
      exp_res   = exp_res_tab;
      exp_alarm = exp_alarm_tab;
    end else begin
      exp_res   = (r + S - 1 < HIST) ? risk_hist[r + S - 1] : 8'h00;
      exp_alarm = (exp_res >= 8'd200);
    end
    checkOutput("res_data", res_data_w[d], exp_res);
    checkOutput("result_in_ready", in_ready_w[d], 0);
`ifdef RISK_ALARM_EN
    checkOutput("alarm", alarm_w[d], exp_alarm);
`endif

    if (!rdy_hi) begin
      for (int k = 0; k < rdy; k++) begin
        tick();
        checkOutput("hold_res_valid", res_valid_w[d], 1);
        checkOutput("hold_res_data", res_data_w[d], exp_res);
        checkOutput("hold_in_ready", in_ready_w[d], 0);
      end
      applyStimulus(d, 1'b0, 8'($urandom), 1'b1);
    end
    tick();
    checkOutput("post_hs_res_valid", res_valid_w[d], 0);
    applyStimulus(d, 1'b0, 8'($urandom), 1'b0);

    waited = 0;
    while (!in_ready_w[d] && waited < 50) begin
      checkOutput("gap_busy", busy_w[d], 1);
      tick();
      waited++;
    end
    checkOutput("gap_len", waited, G);
    checkOutput("idle_busy", busy_w[d], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    risk_in = 8'h00;
    last_rise[0] = -1;
    last_rise[1] = -1;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);

    vecs[0] = '{0, 8'h3C, 8'hA5, 8'h57, 0, 2, 8'h57, 1'b0};
    vecs[1] = '{1, 8'h11, 8'hEE, 8'h42, 3, 0, 8'h42, 1'b0};
    vecs[2] = '{0, 8'h00, 8'hFF, 8'd199, 1, 10, 8'd199, 1'b0};
    vecs[3] = '{0, 8'h81, 8'h7E, 8'd200, 0, -1, 8'd200, 1'b1};
    vecs[4] = '{0, 8'hFF, 8'h00, 8'd255, 0, -1, 8'd255, 1'b1};
    vecs[5] = '{1, 8'h5A, 8'hA5, 8'h00, 2, -1, 8'h00, 1'b0};

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_ss_n", ss_n_w[d], 1);
      checkOutput("rst_bus", data_bus_w[d], 0);
      checkOutput("rst_in_ready", in_ready_w[d], 0);
      checkOutput("rst_res_valid", res_valid_w[d], 0);
      checkOutput("rst_res_data", res_data_w[d], 0);
      checkOutput("rst_busy", busy_w[d], 0);
`ifdef RISK_ALARM_EN
      checkOutput("rst_alarm", alarm_w[d], 0);
`endif
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].dut, vecs[i].b0, vecs[i].b1, vecs[i].gap, vecs[i].rdy,
                1'b1, vecs[i].risk, vecs[i].exp_res, vecs[i].exp_alarm);
    end

    // Reset asserted during the second SEND cycle of dut_a.
    risk_fixed = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    for (int w = 0; w < 50 && !in_ready_w[0]; w++) tick();
    applyStimulus(0, 1'b1, 8'h96, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 8'h69, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_send1_ss_n", ss_n_w[0], 0);
    checkOutput("mid_send1_bus", data_bus_w[0], 8'h96);
    tick();
    checkOutput("mid_send2_ss_n", ss_n_w[0], 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ss_n", ss_n_w[0], 1);
    checkOutput("rst_mid_busy", busy_w[0], 0);
    checkOutput("rst_mid_res_valid", res_valid_w[0], 0);
    checkOutput("rst_mid_res_data", res_data_w[0], 0);
    checkOutput("rst_mid_bus", data_bus_w[0], 0);
    checkOutput("rst_mid_in_ready", in_ready_w[0], 0);
    tick();
    rst_n = 1'b1;
    last_rise[0] = -1;
    last_rise[1] = -1;
    run_frame(0, 8'h3C, 8'hA5, 0, 1, 1'b1, 8'h57, 8'h57, 1'b0);

    // Randomized frames against the bench model; rdy < 0 means back-to-back.
    for (int i = 0; i < 30; i++) begin
      run_frame(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 1,
                1'b0, 8'h00, 8'h00, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
